retry_grant_sched: RTL and testbench
====================================

// Module: retry_grant_sched
// PURPOSE
//  Round-robin, credit-gated scheduler that drives the retry engine grant channel
//  (vld_out_grant / grant_des_id / rdy_out_grant).
//  Arbitrates up to 16 destination requesters; one grant consumes one destination credit.
//  Credits are returned by the downstream consumer.
//  Sits between the per-destination request logic and the retry engine output stage.
// PARAMETERS
//  NUM_REQ  16  number of requesters/destinations (2..16)
//  ID_BW    4   width of grant_des_id / crd_rtn_id (>= clog2(NUM_REQ))
//  CRD_BW   3   width of per-destination credit counter
//  MAX_CRD  4   credits per destination after reset (1..2**CRD_BW-1)
//  TMO_CYC  256 stall cycles before timeout flag (only with RETRY_GRANT_TMO_EN)
// PORTS
//  clk            in   1        clock, all logic on posedge
//  rst_n          in   1        asynchronous active-low reset
//  req_vld        in   NUM_REQ  level request per destination
//  crd_rtn_vld    in   1        credit return strobe, one credit per cycle
//  crd_rtn_id     in   ID_BW    destination receiving the returned credit
//  vld_out_grant  out  1        grant valid
//  grant_des_id   out  ID_BW    granted destination
//  rdy_out_grant  in   1        grant accepted by consumer
//  busy           out  1        1 while state==GRANT
//  err_crd_ovf    out  1        sticky: credit returned to full counter
//  err_timeout    out  1        sticky stall flag (tied 0 without RETRY_GRANT_TMO_EN)
// BEHAVIOUR
//  Reset (async, immediate): vld_out_grant=0, grant_des_id=0, busy=0, err_*=0,
//   rr pointer=0, all credits=MAX_CRD, state=IDLE.
//  Eligible[i] = req_vld[i] && crd[i]!=0.
//   Winner = first eligible index at or after ptr, wrapping modulo NUM_REQ.
//  FSM IDLE: any eligible -> GRANT; load winner into grant_des_id, vld_out_grant=1
//   next cycle (1-cycle registered latency req->grant).
//  FSM GRANT: vld_out_grant, grant_des_id held stable until rdy_out_grant=1.
//   Dropping req_vld does not withdraw an issued grant.
//  Handshake (vld&&rdy) on winner w: crd[w]-=1; ptr=(w+1)%NUM_REQ.
//   Eligibility re-evaluated with post-update credits and new ptr.
//   Any eligible -> stay GRANT with new winner (back-to-back, no bubble).
//   None -> IDLE, vld_out_grant=0.
//  Credit return: crd[crd_rtn_id]+=1 at posedge.
//   Return and consume on same id in same cycle -> net unchanged.
//   Return to counter already at MAX_CRD -> ignored, err_crd_ovf set (sticky until reset).
//   crd_rtn_id >= NUM_REQ -> ignored, err_crd_ovf set.
//  Credits never go negative; grant requires crd>0 at selection time.
//  Returned credit makes its destination eligible the cycle after return.
//  Reset mid-grant: grant dropped immediately; no handshake implied; credits restored.
// CONFIGURATION
//  RETRY_GRANT_TMO_EN defined:
//   16-bit stall counter increments each cycle vld_out_grant&&!rdy_out_grant.
//   Clears on handshake or IDLE.
//   Reaching TMO_CYC sets err_timeout (sticky); the grant stays held (no drop, no re-arbitration).
//  Undefined: no counter logic, err_timeout constant 0, TMO_CYC unused.
// TESTING
//  req_vld=16'h0001, rdy=1 -> grants id0 on 4 consecutive cycles, then vld=0;
//   crd[0]=0 until a return.
//  req_vld=16'h8421, rdy=1 -> grant order 0,5,10,15,0,5... with no idle cycles.
//  req_vld=16'h0006, rdy=0 for 10 cycles -> grant_des_id=1 stable, vld=1 throughout;
//   rdy=1 -> next grant id2.
//  crd[3]=0, crd_rtn_vld with id 3 -> id3 granted 2 cycles after return;
//   return to full id7 -> err_crd_ovf=1.
//  Same-cycle handshake id2 + crd_rtn id2 with crd[2]=2 -> crd[2] stays 2.
//  RETRY_GRANT_TMO_EN, TMO_CYC=8, rdy=0 -> err_timeout=1 after 8 stalled cycles;
//   grant still held. Then rst_n=0 mid-grant -> vld=0 at once, all credits=4.

Source files
------------

// File: rtl/retry_grant_sched_if.sv
// Grant-channel interface for retry_grant_sched.
// Bundles the request vector, credit-return strobe, grant handshake and the
// status/error outputs. The master modport is the scheduler side; the slave
// modport is the requester/consumer side.
interface retry_grant_sched_if #(
  parameter int NUM_REQ = 16,
  parameter int ID_BW   = 4
);
  logic [NUM_REQ-1:0] req_vld;
  logic               crd_rtn_vld;
  logic [ID_BW-1:0]   crd_rtn_id;
  logic               vld_out_grant;
  logic [ID_BW-1:0]   grant_des_id;
  logic               rdy_out_grant;
  logic               busy;
  logic               err_crd_ovf;
  logic               err_timeout;

  modport master (
    input  req_vld, crd_rtn_vld, crd_rtn_id, rdy_out_grant,
    output vld_out_grant, grant_des_id, busy, err_crd_ovf, err_timeout
  );

  modport slave (
    output req_vld, crd_rtn_vld, crd_rtn_id, rdy_out_grant,
    input  vld_out_grant, grant_des_id, busy, err_crd_ovf, err_timeout
  );
endinterface

// File: rtl/retry_grant_sched.sv
// Round-robin, credit-gated grant scheduler for the retry engine.
// Each destination owns a credit counter. A grant is issued only to a
// requester holding at least one credit, and each accepted grant consumes one
// credit. Credits come back through the crd_rtn_* strobe.
// Optional feature: define RETRY_GRANT_TMO_EN to build the stall-timeout
// counter that drives err_timeout. Without it err_timeout is tied to 0.
module retry_grant_sched #(
  parameter int NUM_REQ = 16,
  parameter int ID_BW   = 4,
  parameter int CRD_BW  = 3,
  parameter int MAX_CRD = 4,
  parameter int TMO_CYC = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  retry_grant_sched_if.master gif
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CRD_BW-1:0] MAX_C = CRD_BW'(MAX_CRD);

  state_e                          state_q, state_d;
  logic                            vld_q, vld_d;
  logic [ID_BW-1:0]                gid_q, gid_d;
  logic [ID_BW-1:0]                ptr_q, ptr_d;
  logic                            busy_q, busy_d;
  logic                            ovf_q, ovf_d;
  logic [NUM_REQ-1:0][CRD_BW-1:0]  crd_q, crd_d;

  logic [NUM_REQ-1:0]              elig;
  logic [NUM_REQ-1:0]              consume;
  logic [NUM_REQ-1:0]              rtn;
  logic [ID_BW-1:0]                sel_ptr;
  logic                            hs;
  logic                            rtn_in_range;

`ifdef RETRY_GRANT_TMO_EN
  logic [15:0]                     stall_q, stall_d;
  logic                            tmo_q, tmo_d;
`endif

  // First set bit of e at or after p, wrapping modulo NUM_REQ.
  function automatic logic [ID_BW-1:0] pick(input logic [NUM_REQ-1:0] e,
                                            input logic [ID_BW-1:0]   p);
    logic [ID_BW-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && e[idx]) begin
        res   = ID_BW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Next-state: credit bookkeeping, arbitration and grant FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    vld_d   = vld_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    crd_d   = crd_q;
    elig    = '0;
    consume = '0;
    rtn     = '0;

    hs           = vld_q && gif.rdy_out_grant;
    rtn_in_range = int'(gif.crd_rtn_id) < NUM_REQ;
    ovf_d        = ovf_q || (gif.crd_rtn_vld && !rtn_in_range);

    for (int i = 0; i < NUM_REQ; i++) begin
      consume[i] = hs && (gid_q == ID_BW'(i));
      rtn[i]     = gif.crd_rtn_vld && (gif.crd_rtn_id == ID_BW'(i));
      // Eligibility sees this cycle's consumption but not this cycle's return.
      elig[i]    = gif.req_vld[i] && (crd_q[i] != '0) &&
                   !(consume[i] && (crd_q[i] == CRD_BW'(1)));
      if (rtn[i] && !consume[i]) begin
        if (crd_q[i] == MAX_C) ovf_d    = 1'b1;
        else                   crd_d[i] = crd_q[i] + CRD_BW'(1);
      end else if (consume[i] && !rtn[i]) begin
        crd_d[i] = crd_q[i] - CRD_BW'(1);
      end
    end

    // After a handshake the search restarts just past the winner.
    sel_ptr = ptr_q;
    if (hs) sel_ptr = (int'(gid_q) == NUM_REQ - 1) ? '0 : gid_q + ID_BW'(1);

    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = GRANT;
          vld_d   = 1'b1;
          gid_d   = pick(elig, ptr_q);
        end
      end
      GRANT: begin
        // Without a handshake the issued grant is held unchanged.
        if (hs) begin
          ptr_d = sel_ptr;
          if (|elig) begin
            gid_d = pick(elig, sel_ptr);
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == GRANT);

`ifdef RETRY_GRANT_TMO_EN
    // Count consecutive stalled cycles; a handshake or idle clears the count.
    stall_d = '0;
    tmo_d   = tmo_q;
    if (vld_q && !gif.rdy_out_grant) begin
      stall_d = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
      if (int'(stall_q) + 1 >= TMO_CYC) tmo_d = 1'b1;
    end
`endif
  end

  // State, registered outputs and credit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      // NOTE: the credit array is real state that must start full, so it is reset like any flop.
      for (int i = 0; i < NUM_REQ; i++) crd_q[i] <= MAX_C;
`ifdef RETRY_GRANT_TMO_EN
      stall_q <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      vld_q   <= vld_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      crd_q   <= crd_d;
`ifdef RETRY_GRANT_TMO_EN
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gif.vld_out_grant = vld_q;
  assign gif.grant_des_id  = gid_q;
  assign gif.busy          = busy_q;
  assign gif.err_crd_ovf   = ovf_q;
`ifdef RETRY_GRANT_TMO_EN
  assign gif.err_timeout   = tmo_q;
`else
  assign gif.err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_retry_grant_sched.sv
// Self-checking bench for retry_grant_sched.
// A behavioural model (integer credit array, pointer and current grant id)
// follows the scheduling rules cycle by cycle; directed scenarios also carry
// hand-derived constant expectations.
module tb_retry_grant_sched;
  localparam int N   = 16;
  localparam int MAX = 4;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;

  retry_grant_sched_if #(.NUM_REQ(N), .ID_BW(4)) g ();

  retry_grant_sched #(
    .NUM_REQ(N), .ID_BW(4), .CRD_BW(3), .MAX_CRD(MAX), .TMO_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .gif  (g)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_crd[N];
  int m_ptr;
  int m_gid;     // -1 when no grant is outstanding
  bit m_ovf;
  bit m_tmo;
  int m_stall;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_crd[i] = MAX;
    m_ptr   = 0;
    m_gid   = -1;
    m_ovf   = 1'b0;
    m_tmo   = 1'b0;
    m_stall = 0;
  endfunction

  // One clock edge of the scheduling rules.
  function automatic void m_step(logic [N-1:0] r, bit rd, bit rv, int rid);
    int avail[N];
    int consumed;
    bit hs;
    consumed = -1;
    hs = (m_gid >= 0) && rd;
`ifdef RETRY_GRANT_TMO_EN
    if (m_gid >= 0 && !rd) begin
      m_stall++;
      if (m_stall >= TMO) m_tmo = 1'b1;
    end else begin
      m_stall = 0;
    end
`endif
    if (hs) begin
      consumed = m_gid;
      m_crd[m_gid]--;
      m_ptr = (m_gid + 1) % N;
    end
    avail = m_crd;
    if (rv) begin
      if (rid >= N)                                m_ovf = 1'b1;
      else if (rid == consumed)                    m_crd[rid]++;
      else if (m_crd[rid] == MAX)                  m_ovf = 1'b1;
      else                                         m_crd[rid]++;
    end
    if (m_gid < 0 || hs) begin
      m_gid = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_gid < 0 && r[i] && avail[i] > 0) m_gid = i;
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge, and return 1 ns later so outputs can be sampled.
  task automatic cyc(input logic [N-1:0] r, input bit rd, input bit rv, input int rid);
    @(negedge clk);
    g.req_vld       = r;
    g.rdy_out_grant = rd;
    g.crd_rtn_vld   = rv;
    g.crd_rtn_id    = 4'(rid);
    @(posedge clk);
    m_step(r, rd, rv, rid);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    g.req_vld       = '0;
    g.rdy_out_grant = 1'b0;
    g.crd_rtn_vld   = 1'b0;
    g.crd_rtn_id    = '0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    g.req_vld       = '0;
    g.rdy_out_grant = 1'b0;
    g.crd_rtn_vld   = 1'b0;
    g.crd_rtn_id    = '0;
    m_reset();
    #3;
    n_cmp++; if (g.vld_out_grant !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", g.vld_out_grant); end
    n_cmp++; if (g.grant_des_id !== 4'd0)  begin n_bad++; $display("FAIL reset_id: got %0d want 0", g.grant_des_id); end
    n_cmp++; if (g.busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy: got %b want 0", g.busy); end
    n_cmp++; if (g.err_crd_ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b want 0", g.err_crd_ovf); end
    n_cmp++; if (g.err_timeout !== 1'b0)   begin n_bad++; $display("FAIL reset_tmo: got %b want 0", g.err_timeout); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single requester drains its four credits in four back-to-back grants.
  task automatic test_single();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      logic exp_v;
      cyc(16'h0001, 1'b1, 1'b0, 0);
      exp_v = (k < 4);
      n_cmp++; if (g.vld_out_grant !== exp_v) begin n_bad++; $display("FAIL single_vld[%0d]: got %b want %b", k, g.vld_out_grant, exp_v); end
      n_cmp++; if (g.busy !== exp_v)          begin n_bad++; $display("FAIL single_busy[%0d]: got %b want %b", k, g.busy, exp_v); end
      if (exp_v) begin
        n_cmp++; if (g.grant_des_id !== 4'd0) begin n_bad++; $display("FAIL single_id[%0d]: got %0d want 0", k, g.grant_des_id); end
      end
    end
  endtask

  // Four requesters served in strict rotation with no idle cycles.
  task automatic test_rr();
    logic [3:0] order [4];
    order[0] = 4'd0; order[1] = 4'd5; order[2] = 4'd10; order[3] = 4'd15;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(16'h8421, 1'b1, 1'b0, 0);
      n_cmp++; if (g.vld_out_grant !== 1'b1)     begin n_bad++; $display("FAIL rr_vld[%0d]: got %b want 1", k, g.vld_out_grant); end
      n_cmp++; if (g.grant_des_id !== order[k%4]) begin n_bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, g.grant_des_id, order[k%4]); end
    end
  endtask

  // Grant held stable under back-pressure, then advances on acceptance.
  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(16'h0006, 1'b0, 1'b0, 0);
      n_cmp++; if (g.vld_out_grant !== 1'b1) begin n_bad++; $display("FAIL stall_vld[%0d]: got %b want 1", k, g.vld_out_grant); end
      n_cmp++; if (g.grant_des_id !== 4'd1)  begin n_bad++; $display("FAIL stall_id[%0d]: got %0d want 1", k, g.grant_des_id); end
    end
    cyc(16'h0006, 1'b1, 1'b0, 0);
    n_cmp++; if (g.vld_out_grant !== 1'b1) begin n_bad++; $display("FAIL stall_next_vld: got %b want 1", g.vld_out_grant); end
    n_cmp++; if (g.grant_des_id !== 4'd2)  begin n_bad++; $display("FAIL stall_next_id: got %0d want 2", g.grant_des_id); end
  endtask

  // Exhausted destination regains eligibility one cycle after a return;
  // a return to a full counter flags overflow.
  task automatic test_credit_return();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      logic exp_v;
      cyc(16'h0008, 1'b1, 1'b0, 0);
      exp_v = (k < 4);
      n_cmp++; if (g.vld_out_grant !== exp_v) begin n_bad++; $display("FAIL drain3_vld[%0d]: got %b want %b", k, g.vld_out_grant, exp_v); end
    end
    cyc(16'h0008, 1'b1, 1'b1, 3);
    n_cmp++; if (g.vld_out_grant !== 1'b0) begin n_bad++; $display("FAIL rtn3_early_vld: got %b want 0", g.vld_out_grant); end
    cyc(16'h0008, 1'b1, 1'b0, 0);
    n_cmp++; if (g.vld_out_grant !== 1'b1) begin n_bad++; $display("FAIL rtn3_vld: got %b want 1", g.vld_out_grant); end
    n_cmp++; if (g.grant_des_id !== 4'd3)  begin n_bad++; $display("FAIL rtn3_id: got %0d want 3", g.grant_des_id); end
    n_cmp++; if (g.err_crd_ovf !== 1'b0)   begin n_bad++; $display("FAIL rtn3_ovf: got %b want 0", g.err_crd_ovf); end
    cyc(16'h0000, 1'b1, 1'b1, 7);
    n_cmp++; if (g.err_crd_ovf !== 1'b1)   begin n_bad++; $display("FAIL ovf7: got %b want 1", g.err_crd_ovf); end
    for (int k = 0; k < 3; k++) begin
      cyc(16'h0000, 1'b0, 1'b0, 0);
      n_cmp++; if (g.err_crd_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky[%0d]: got %b want 1", k, g.err_crd_ovf); end
    end
  endtask

  // Handshake and return on the same id in the same cycle leave the count unchanged.
  task automatic test_same_cycle();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      logic exp_v;
      cyc(16'h0004, 1'b1, (k == 3), 2);
      exp_v = (k < 5);
      n_cmp++; if (g.vld_out_grant !== exp_v) begin n_bad++; $display("FAIL same_vld[%0d]: got %b want %b", k, g.vld_out_grant, exp_v); end
    end
    n_cmp++; if (g.err_crd_ovf !== 1'b0) begin n_bad++; $display("FAIL same_ovf: got %b want 0", g.err_crd_ovf); end
  endtask

  // Randomised traffic against the reference model.
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      bit           rd;
      bit           rv;
      int           rid;
      r   = N'($urandom) & N'($urandom);
      rd  = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 3);
      rid = $urandom_range(0, N - 1);
      cyc(r, rd, rv, rid);
      n_cmp++; if (g.vld_out_grant !== (m_gid >= 0)) begin n_bad++; $display("FAIL rnd_vld[%0d]: got %b want %b", k, g.vld_out_grant, (m_gid >= 0)); end
      n_cmp++; if (g.busy !== (m_gid >= 0))          begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, g.busy, (m_gid >= 0)); end
      if (m_gid >= 0) begin
        n_cmp++; if (g.grant_des_id !== 4'(m_gid)) begin n_bad++; $display("FAIL rnd_id[%0d]: got %0d want %0d", k, g.grant_des_id, m_gid); end
      end
      n_cmp++; if (g.err_crd_ovf !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", k, g.err_crd_ovf, m_ovf); end
      n_cmp++; if (g.err_timeout !== m_tmo) begin n_bad++; $display("FAIL rnd_tmo[%0d]: got %b want %b", k, g.err_timeout, m_tmo); end
    end
  endtask

`ifdef RETRY_GRANT_TMO_EN
  // Stall long enough to trip the timeout; the grant must stay held.
  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      logic exp_t;
      cyc(16'h0002, 1'b0, 1'b0, 0);
      exp_t = (k >= TMO);
      n_cmp++; if (g.err_timeout !== exp_t)  begin n_bad++; $display("FAIL tmo_flag[%0d]: got %b want %b", k, g.err_timeout, exp_t); end
      n_cmp++; if (g.vld_out_grant !== 1'b1) begin n_bad++; $display("FAIL tmo_vld[%0d]: got %b want 1", k, g.vld_out_grant); end
      n_cmp++; if (g.grant_des_id !== 4'd1)  begin n_bad++; $display("FAIL tmo_id[%0d]: got %0d want 1", k, g.grant_des_id); end
    end
  endtask
`endif

  // Asynchronous reset while a grant is pending drops it at once and
  // restores full credits.
  task automatic test_reset_mid_grant();
    do_reset();
    for (int k = 0; k < 3; k++) cyc(16'h0002, 1'b0, 1'b0, 0);
    n_cmp++; if (g.vld_out_grant !== 1'b1) begin n_bad++; $display("FAIL mid_pre_vld: got %b want 1", g.vld_out_grant); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (g.vld_out_grant !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld: got %b want 0", g.vld_out_grant); end
    n_cmp++; if (g.busy !== 1'b0)          begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", g.busy); end
    n_cmp++; if (g.err_timeout !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_tmo: got %b want 0", g.err_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic exp_v;
      cyc(16'h0001, 1'b1, 1'b0, 0);
      exp_v = (k < 4);
      n_cmp++; if (g.vld_out_grant !== exp_v) begin n_bad++; $display("FAIL mid_after_vld[%0d]: got %b want %b", k, g.vld_out_grant, exp_v); end
      n_cmp++; if (g.vld_out_grant !== (m_gid >= 0)) begin n_bad++; $display("FAIL mid_after_model[%0d]: got %b want %b", k, g.vld_out_grant, (m_gid >= 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_credit_return();
    test_same_cycle();
    test_random();
`ifdef RETRY_GRANT_TMO_EN
    test_timeout();
`endif
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
